window_shift_buffer: RTL
========================

# window_shift_buffer

Parametrised K×K sliding-window register array for the neighbourhood stages of the edge-detection pipeline: Gaussian blur, Sobel gradient and non-maximum suppression. Each accepted beat shifts the window right, left or down and inserts one new column or row. A fill counter tracks when the window holds K fresh lines. A valid/ready pair on both sides presents each full window to the downstream kernel exactly once and stalls the source under backpressure.

## Interface
- DATA_W, 8, pixel width in bits
- K, 3, window edge length; odd, 3..7
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of window, fill count and output valid
- in_valid  in  1  source presents col_in/shift_dir
- in_ready  out  1  beat accepted when in_valid & in_ready
- shift_dir  in  2  00 none, 01 right, 10 left, 11 down
- col_in  in  K*DATA_W  new line; element i at [i*DATA_W +: DATA_W]
- win_out  out  K*K*DATA_W  window; element [r][c] at [(r*K+c)*DATA_W +: DATA_W]
- win_valid  out  1  win_out holds a complete, not-yet-consumed window
- out_ready  in  1  downstream consumes the window when win_valid & out_ready
- fill  out  $clog2(K+1)  fresh lines in window, saturating at K

## Operation
- Reset: all window elements 0, fill 0, win_valid 0; in_ready 1 once n_rst deasserts.
- Accepted beat (in_valid & in_ready & ~clear) has the following effect by direction:
  - right: [r][c] ← [r][c+1] for c<K-1; [r][K-1] ← col_in[r].
  - left: [r][c] ← [r][c-1] for c>0; [r][0] ← col_in[r].
  - down: [r][c] ← [r+1][c] for r<K-1; [K-1][c] ← col_in[c].
  - none: beat is consumed; window and fill are unchanged; no win_valid is produced.
- fill increments by 1 on each accepted non-none shift and saturates at K. A change between horizontal and vertical shifting does not reset fill; snake-scan sources rely on this.
- win_valid sets on the edge after an accepted non-none shift whose post-shift fill equals K. It clears on the edge where out_ready is sampled high and no new qualifying shift is accepted in the same cycle.
- in_ready = ~clear & (~win_valid | out_ready), combinational. The window never changes while an unconsumed window is held.
- clear: window elements go to 0, fill to 0, and win_valid to 0 on the next edge. clear overrides a simultaneous in_valid; that beat is not accepted because in_ready is 0.
- Reset mid-operation: all state returns to reset values immediately, with no pending window preserved.

## Timing
- Shift latency: 1 cycle. win_out reflects a beat on the edge that accepts it.
- win_valid asserts on that same edge and is never combinational from in_valid.
- Throughput: 1 window per cycle when out_ready is held high.
- Simultaneous consume and new shift: win_valid stays 1, win_out updates, and the next window is presented with no bubble.
- out_ready sampled while win_valid is 0 has no effect.

## Structure
- Package window_pkg holds:
  - shift_dir_t enum: SHIFT_NONE, SHIFT_RIGHT, SHIFT_LEFT, SHIFT_DOWN, with the encodings above.
  - Function win_idx(r, c, K) returning the flat element offset.
- Sub-module window_fill_ctrl holds fill, win_valid and in_ready, exposing an accept strobe to the datapath. The shift array stays in the top module as a generate-loop register array.

## Test plan
- Reset, then 3 right shifts (K=3, DATA_W=8) with col_in = {r+1, r+11, r+21} per beat and out_ready=1:
  - fill goes 1,2,3.
  - win_valid is 1 only after the 3rd beat.
  - win_out row0 = 1,11,21.
- Full window held with out_ready=0 and in_valid=1 for 4 cycles: in_ready=0 and win_out is stable. out_ready=1 then consumes it and the stalled beat is accepted on the same edge.
- Left shift and down shift with known col_in each match the element-mapping rules. A down shift after 3 right shifts keeps fill=3 and produces win_valid.
- shift_dir=00 beat with in_valid=1: in_ready=1, win_out and fill unchanged, win_valid stays 0.
- clear asserted together with in_valid while win_valid=1:
  - in_ready=0.
  - Next cycle: fill=0, win_valid=0, window all zeros.
- n_rst pulsed low mid-stream (fill=2): outputs return to zero immediately. K=5 regression requires 5 shifts before the first win_valid.

Source files
------------

// File: rtl/window_pkg.sv
// window_pkg: shared shift-direction encoding and window element addressing
package window_pkg;

  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_RIGHT = 2'b01,
    SHIFT_LEFT  = 2'b10,
    SHIFT_DOWN  = 2'b11
  } shift_dir_t;

  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/window_fill_ctrl.sv
// window_fill_ctrl: fill counter, window-valid flag and source handshake
module window_fill_ctrl
  import window_pkg::*;
#(
  parameter int K = 3
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [1:0]             shift_dir,
  input  logic                   out_ready,
  output logic                   in_ready,
  output logic                   accept,
  output logic [$clog2(K+1)-1:0] fill,
  output logic                   win_valid
);

  localparam int FW = $clog2(K+1);

  logic [FW-1:0] fill_q, fill_d;
  logic          win_valid_q, win_valid_d;
  logic          shift;

  // a consuming sink reopens in_ready in the same cycle so windows stream without bubbles
  always_comb begin
    in_ready    = ~clear & (~win_valid_q | out_ready);
    accept      = in_valid & in_ready;
    shift       = accept & (shift_dir != SHIFT_NONE);
    fill_d      = clear ? '0 : (shift && fill_q != FW'(K)) ? fill_q + FW'(1) : fill_q;
    win_valid_d = clear ? 1'b0 : shift ? (fill_d == FW'(K)) : out_ready ? 1'b0 : win_valid_q;
  end

  // fill and window-valid state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fill_q      <= '0;
      win_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign fill      = fill_q;
  assign win_valid = win_valid_q;

endmodule

// File: rtl/window_shift_buffer.sv
// window_shift_buffer: KxK sliding pixel window with right/left/down shifts and valid/ready
module window_shift_buffer
  import window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              shift_dir,
  input  logic [K*DATA_W-1:0]     col_in,
  output logic [K*K*DATA_W-1:0]   win_out,
  output logic                    win_valid,
  input  logic                    out_ready,
  output logic [$clog2(K+1)-1:0]  fill
);

  logic                  accept;
  shift_dir_t            dir;
  logic [K*K*DATA_W-1:0] win_q, win_d;

  assign dir = shift_dir_t'(shift_dir);

  window_fill_ctrl #(.K(K)) u_fill (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .shift_dir (shift_dir),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .accept    (accept),
    .fill      (fill),
    .win_valid (win_valid)
  );

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      localparam int I = win_idx(r, c, K);
      logic [DATA_W-1:0] cur, rt, lf, dn;
      assign cur = win_q[I*DATA_W +: DATA_W];
      if (c == K-1) begin : g_rt_in
        assign rt = col_in[r*DATA_W +: DATA_W];
      end else begin : g_rt_sh
        assign rt = win_q[win_idx(r, c+1, K)*DATA_W +: DATA_W];
      end
      if (c == 0) begin : g_lf_in
        assign lf = col_in[r*DATA_W +: DATA_W];
      end else begin : g_lf_sh
        assign lf = win_q[win_idx(r, c-1, K)*DATA_W +: DATA_W];
      end
      if (r == K-1) begin : g_dn_in
        assign dn = col_in[c*DATA_W +: DATA_W];
      end else begin : g_dn_sh
        assign dn = win_q[win_idx(r+1, c, K)*DATA_W +: DATA_W];
      end
      // a none beat is accepted but leaves the element untouched
      assign win_d[I*DATA_W +: DATA_W] = clear ? '0 :
                                         !accept ? cur :
                                         dir == SHIFT_RIGHT ? rt :
                                         dir == SHIFT_LEFT  ? lf :
                                         dir == SHIFT_DOWN  ? dn : cur;
    end
  end

  // window register array
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) win_q <= '0;
    else        win_q <= win_d;
  end

  assign win_out = win_q;

endmodule
